// File: rtl/wb_multi_counter.sv
// Multi-channel Wishbone timer/counter: NCH channels of BITS-wide up/down counters with prescaler, compare, reload, one-shot, IRQ.
// Latency: Wishbone ack and read data are registered, one cycle after the request is first seen; counts update on the tick edge.
// Backpressure: none; each access completes in one cycle, and a held strobe gives one access every two cycles.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i    Wishbone cycle, strobe, write enable
//   wbs_sel_i               byte enables
//   wbs_adr_i               byte address; [7:4] channel, [3:2] register (CTRL, COUNT, CMP, STATUS)
//   wbs_dat_i / wbs_dat_o   write data / registered read data
//   wbs_ack_o               registered single-cycle acknowledge
//   count_o                 channel counts, channel n at [n*BITS +: BITS]
//   irq_o                   OR over channels of MATCH & IE
module wb_multi_counter #(
    parameter int NCH  = 4,
    parameter int BITS = 32
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic [NCH*BITS-1:0] count_o,
    output logic                irq_o
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_CMP    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // Per-channel control fields
    logic [NCH-1:0]  en_q, en_d;
    logic [NCH-1:0]  dir_q, dir_d;
    logic [NCH-1:0]  reload_q, reload_d;
    logic [NCH-1:0]  oneshot_q, oneshot_d;
    logic [NCH-1:0]  ie_q, ie_d;
    logic [NCH-1:0]  match_q, match_d;
    logic [7:0]      presc_q [NCH];
    logic [7:0]      presc_d [NCH];
    logic [7:0]      pcnt_q  [NCH];
    logic [7:0]      pcnt_d  [NCH];
    logic [BITS-1:0] count_q [NCH];
    logic [BITS-1:0] count_d [NCH];
    logic [BITS-1:0] cmp_q   [NCH];
    logic [BITS-1:0] cmp_d   [NCH];

    // Bus side
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        acc;
    logic [3:0]  ch_sel;
    logic [1:0]  reg_sel;
    logic [31:0] rd_dat;
    logic        unused_adr;

    // An access is taken only on an edge where ack is not already high,
    // which spaces a held strobe into one access every two cycles.
    assign acc        = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign ch_sel     = wbs_adr_i[7:4];
    assign reg_sel    = wbs_adr_i[3:2];
    assign unused_adr = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};

    // Read mux: channels at or above NCH fall through to zero.
    always_comb begin
        rd_dat = '0;
        for (int n = 0; n < NCH; n++) begin
            if (ch_sel == 4'(n)) begin
                case (reg_sel)
                    REG_CTRL:  rd_dat = {16'd0, presc_q[n], 3'd0, ie_q[n], oneshot_q[n],
                                         reload_q[n], dir_q[n], en_q[n]};
                    REG_COUNT: rd_dat = 32'(count_q[n]);
                    REG_CMP:   rd_dat = 32'(cmp_q[n]);
                    default:   rd_dat = {31'd0, match_q[n]};
                endcase
            end
        end
    end

    always_comb begin
        logic            wr_ch;
        logic            wr_ctrl;
        logic            wr_count;
        logic            wr_cmp;
        logic            wr_status;
        logic            tick;
        logic            hit;
        logic            set_match;
        logic [BITS-1:0] step;

        en_d      = en_q;
        dir_d     = dir_q;
        reload_d  = reload_q;
        oneshot_d = oneshot_q;
        ie_d      = ie_q;
        match_d   = match_q;
        presc_d   = presc_q;
        pcnt_d    = pcnt_q;
        count_d   = count_q;
        cmp_d     = cmp_q;
        wr_ch     = 1'b0;
        wr_ctrl   = 1'b0;
        wr_count  = 1'b0;
        wr_cmp    = 1'b0;
        wr_status = 1'b0;
        tick      = 1'b0;
        hit       = 1'b0;
        set_match = 1'b0;
        step      = '0;

        for (int n = 0; n < NCH; n++) begin
            wr_ch     = acc & wbs_we_i & (ch_sel == 4'(n));
            wr_ctrl   = wr_ch & (reg_sel == REG_CTRL);
            wr_count  = wr_ch & (reg_sel == REG_COUNT);
            wr_cmp    = wr_ch & (reg_sel == REG_CMP);
            wr_status = wr_ch & (reg_sel == REG_STATUS);

            tick = en_q[n] & (pcnt_q[n] == presc_q[n]);
            hit  = dir_q[n] ? (count_q[n] == '0) : (count_q[n] == cmp_q[n]);

            if (!dir_q[n]) begin
                step = (hit & reload_q[n]) ? '0 : count_q[n] + BITS'(1);
            end else begin
                step = (hit & reload_q[n]) ? cmp_q[n] : count_q[n] - BITS'(1);
            end

            // A COUNT write swallows the whole tick, including its MATCH.
            set_match = tick & hit & ~wr_count;

            // Prescaler restarts from zero whenever the channel is disabled,
            // reconfigured or reloaded, so the first tick is always PRESC+1 edges out.
            if (!en_q[n] || wr_ctrl || wr_count || tick) begin
                pcnt_d[n] = '0;
            end else begin
                pcnt_d[n] = pcnt_q[n] + 8'd1;
            end

            if (tick && !wr_count) begin
                count_d[n] = step;
                if (hit && oneshot_q[n]) begin
                    en_d[n] = 1'b0;
                end
            end

            // Setting wins over a simultaneous W1C.
            if (set_match) begin
                match_d[n] = 1'b1;
            end else if (wr_status && wbs_sel_i[0] && wbs_dat_i[0]) begin
                match_d[n] = 1'b0;
            end

            // CTRL write is applied after the tick so it overrides the one-shot clear.
            if (wr_ctrl) begin
                if (wbs_sel_i[0]) begin
                    en_d[n]      = wbs_dat_i[0];
                    dir_d[n]     = wbs_dat_i[1];
                    reload_d[n]  = wbs_dat_i[2];
                    oneshot_d[n] = wbs_dat_i[3];
                    ie_d[n]      = wbs_dat_i[4];
                end
                if (wbs_sel_i[1]) begin
                    presc_d[n] = wbs_dat_i[15:8];
                end
            end

            for (int b = 0; b < BITS; b++) begin
                if (wr_count && wbs_sel_i[b/8]) begin
                    count_d[n][b] = wbs_dat_i[b];
                end
                if (wr_cmp && wbs_sel_i[b/8]) begin
                    cmp_d[n][b] = wbs_dat_i[b];
                end
            end
        end

        ack_d = acc;
        dat_d = acc ? rd_dat : dat_q;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            en_q      <= '0;
            dir_q     <= '0;
            reload_q  <= '0;
            oneshot_q <= '0;
            ie_q      <= '0;
            match_q   <= '0;
            for (int n = 0; n < NCH; n++) begin
                presc_q[n] <= '0;
                pcnt_q[n]  <= '0;
                count_q[n] <= '0;
                cmp_q[n]   <= '0;
            end
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            en_q      <= en_d;
            dir_q     <= dir_d;
            reload_q  <= reload_d;
            oneshot_q <= oneshot_d;
            ie_q      <= ie_d;
            match_q   <= match_d;
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
            count_q   <= count_d;
            cmp_q     <= cmp_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = |(match_q & ie_q);

    for (genvar g = 0; g < NCH; g++) begin : g_count
        assign count_o[g*BITS +: BITS] = count_q[g];
    end

endmodule

// File: doc/wb_multi_counter.md
# wb_multi_counter

Multi-channel, parametrised Wishbone timer/counter block for the user project area: the next generation of the single free-running counter. It provides NCH independent channels of BITS width, each with enable, up/down direction, 8-bit prescaler, compare register, auto-reload, one-shot mode and a maskable match interrupt. All channel registers are reached from the management SoC over the Wishbone slave port. Counts are exported for the IO pads and the logic analyzer.

## Interface
- NCH, 4: number of channels, 1..8.
- BITS, 32: counter width per channel, 8..32.
- wb_clk_i  in  1  the only clock; all state on its rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_cyc_i, wbs_stb_i  in  1 each  bus cycle and strobe; valid = cyc & stb.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  byte address; only [7:2] decoded.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  registered acknowledge.
- wbs_dat_o  out  32  registered read data.
- count_o  out  NCH*BITS  channel counts; channel n at [n*BITS +: BITS].
- irq_o  out  1  OR over channels of (MATCH & IE).

## Operation
- Address map: channel = adr[7:4], register = adr[3:2]. 0 CTRL, 1 COUNT, 2 CMP, 3 STATUS.
- CTRL bits:
  - [0] EN.
  - [1] DIR: 0 up, 1 down.
  - [2] RELOAD.
  - [3] ONESHOT.
  - [4] IE.
  - [15:8] PRESC.
  - Other bits read 0.
- STATUS: [0] MATCH, sticky. Writing 1 clears it (W1C); writing 0 has no effect.
- Prescaler: a per-channel 8-bit counter. While EN=1, a tick is generated every PRESC+1 cycles. The prescaler is cleared when EN=0, and on any write to that channel's CTRL or COUNT.
- On each tick, the next count is:
  - Up, count==CMP: RELOAD ? 0 : count+1. Sets MATCH.
  - Down, count==0: RELOAD ? CMP : count-1. Sets MATCH.
  - Otherwise count±1, wrapping modulo 2^BITS.
  - ONESHOT=1 with a match: EN cleared on the same edge.
- Bus writes honour wbs_sel_i per byte. Bits at or above BITS are ignored on write and read 0.
- Channel index >= NCH: access is acked, reads return 0, writes are ignored.
- Simultaneous events:
  - A bus write to COUNT beats a tick in the same cycle; the written value wins and no MATCH is generated.
  - A bus write to CTRL beats a ONESHOT auto-clear.
  - MATCH set beats a W1C clear in the same cycle.
- Reset, including mid-operation: all CTRL/COUNT/CMP/STATUS and prescalers go to 0. wbs_ack_o=0, wbs_dat_o=0, irq_o=0, count_o=0. Takes effect immediately, without waiting for a clock edge.

## Timing
- Handshake:
  - On an edge with valid & !wbs_ack_o, the block sets ack=1 for exactly one cycle.
  - The write and the read data capture happen on that same edge.
  - valid held high produces back-to-back accesses every 2 cycles.
  - If valid drops before ack, the access is abandoned and nothing is written.
- Read data is the register value before that edge's write or tick. It holds until the next access.
- Written values are visible on count_o and in behaviour from the cycle after ack.
- With EN=1 and PRESC=0, the count changes on every edge, starting with the edge after the CTRL write.
- With PRESC=p, the first tick occurs p+1 edges after the enabling write.
- MATCH and the ONESHOT EN-clear register on the tick edge. irq_o is a combinational OR of flops and is high in that following cycle, with no extra latency.

## Test plan
- Reset value: with wb_rst_i asserted mid-count (after channel 0 has been counting) and no clock edge, count_o and irq_o are 0 immediately. Reads of every register after release return 0.
- Free-run wrap: BITS=8, ch0 COUNT=0xFE, CTRL=0x01. count_o[7:0] goes 0xFE,0xFF,0x00,0x01 on successive edges. MATCH is set at the 0x00→0x01 tick, since CMP=0.
- Up reload with IRQ: ch1 CMP=5, CTRL=0x15 (EN, RELOAD, IE). Count sequence is 0..5,0,… and irq_o rises after the 5→0 edge. Write STATUS=1: irq_o drops one cycle after ack.
- Down one-shot with prescale: ch2 COUNT=3, CTRL=0x030B (EN, DIR, ONESHOT, PRESC=3). Decrements every 4 cycles to 0. At the next tick it wraps to 0xFFFFFFFF, MATCH=1 and EN=0. It then holds.
- Collisions:
  - A COUNT write of 0x10 on the same edge as a tick: count=0x10 and no MATCH.
  - A W1C on the same edge as a new match: MATCH stays 1.
- Bus corner cases:
  - A byte write with sel=0b0100 to CMP changes only bits [23:16].
  - A read of channel 7 with NCH=4 acks with 0.
  - valid held for 4 cycles yields exactly 2 acks.
